// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use bubbles,
// EX branch flushes and multi-cycle data-memory stalls with timeout, plus event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             cnt_clr_i,
    output logic             pc_suspend_o,
    output logic             if_id_suspend_o,
    output logic             if_id_flush_o,
    output logic             id_ex_suspend_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_suspend_o,
    output logic             mem_wb_flush_o,
    output logic             redirect_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              mem_stall;
    logic              mem_abort;
    logic              load_use;
    logic              stall_evt;
    logic              flush_evt;

    // State register; reset also cancels any access in flight without a timeout pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state: memory access sequencing with bounded wait.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        mem_abort    = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    mem_stall    = 1'b1;
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt < WAIT_W'(MEM_TIMEOUT)) begin
                    mem_stall    = 1'b1;
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end else begin
                    mem_abort    = 1'b1;
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                       (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

    // Outputs: memory stall dominates, then branch (discards the ID instruction), then load-use.
    always_comb begin
        pc_suspend_o     = 1'b0;
        if_id_suspend_o  = 1'b0;
        if_id_flush_o    = 1'b0;
        id_ex_suspend_o  = 1'b0;
        id_ex_flush_o    = 1'b0;
        ex_mem_suspend_o = 1'b0;
        mem_wb_flush_o   = 1'b0;
        redirect_o       = 1'b0;
        mem_timeout_o    = 1'b0;
        stall_evt        = 1'b0;
        flush_evt        = 1'b0;
        if (!rst_i) begin
            mem_timeout_o = mem_abort;
            if (mem_stall) begin
                pc_suspend_o     = 1'b1;
                if_id_suspend_o  = 1'b1;
                id_ex_suspend_o  = 1'b1;
                ex_mem_suspend_o = 1'b1;
                mem_wb_flush_o   = 1'b1;
                stall_evt        = 1'b1;
            end else if (ex_branch_taken_i) begin
                redirect_o    = 1'b1;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                flush_evt     = 1'b1;
            end else if (load_use) begin
                pc_suspend_o    = 1'b1;
                if_id_suspend_o = 1'b1;
                id_ex_flush_o   = 1'b1;
                stall_evt       = 1'b1;
            end
        end
    end

    // Saturating event counters; clear wins over increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_evt && !(&stall_cnt_o)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_evt && !(&flush_cnt_o)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors with hand-computed
// expectations, checked by an independent monitor on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 2;

    // {pc_susp, if_id_susp, if_id_flush, id_ex_susp, id_ex_flush, ex_mem_susp, mem_wb_flush, redirect, timeout}
    localparam logic [8:0] C_NONE  = 9'b000000000;
    localparam logic [8:0] C_STALL = 9'b110101100;
    localparam logic [8:0] C_BR    = 9'b001010010;
    localparam logic [8:0] C_LU    = 9'b110010000;
    localparam logic [8:0] C_TO    = 9'b000000001;

    typedef struct {
        int         idx;
        logic [8:0] ctrl;
        logic [1:0] s;
        logic [1:0] f;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_mem_read = 1'b0;
    logic ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0, cnt_clr = 1'b0;
    logic pc_suspend, if_id_suspend, if_id_flush, id_ex_suspend, id_ex_flush;
    logic ex_mem_suspend, mem_wb_flush, redirect, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_idx  = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
        .ex_branch_taken_i(ex_branch_taken),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack), .cnt_clr_i(cnt_clr),
        .pc_suspend_o(pc_suspend), .if_id_suspend_o(if_id_suspend),
        .if_id_flush_o(if_id_flush), .id_ex_suspend_o(id_ex_suspend),
        .id_ex_flush_o(id_ex_flush), .ex_mem_suspend_o(ex_mem_suspend),
        .mem_wb_flush_o(mem_wb_flush), .redirect_o(redirect),
        .mem_timeout_o(mem_timeout),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Monitor: the controller presents a response every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("ctrl", e.idx, {pc_suspend, if_id_suspend, if_id_flush, id_ex_suspend,
                  id_ex_flush, ex_mem_suspend, mem_wb_flush, redirect, mem_timeout}, e.ctrl);
            check("stall_cnt", e.idx, 9'(stall_cnt), 9'(e.s));
            check("flush_cnt", e.idx, 9'(flush_cnt), 9'(e.f));
        end
    end

    task automatic step(input logic r, input logic clr,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic mr, input logic br,
                        input logic req, input logic ack,
                        input logic [8:0] ec, input logic [1:0] es, input logic [1:0] ef);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; cnt_clr = clr;
        id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br;
        mem_req = req; mem_ack = ack;
        e.idx = vec_idx; e.ctrl = ec; e.s = es; e.f = ef;
        sb_q.push_back(e);
        vec_idx++;
    endtask

    initial begin
        //   rst clr rs1 u1 rs2 u2 rd  mr br req ack  ctrl     s  f
        step(1, 0, 5, 1, 0, 0, 5, 1, 1, 1, 0, C_NONE,  0, 0);  // 0 reset forces outputs low
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  0, 0);  // 1
        step(0, 0, 5, 1, 0, 0, 5, 1, 0, 0, 0, C_LU,    0, 0);  // 2 load-use on rs1
        step(0, 0, 5, 1, 0, 0, 5, 0, 0, 0, 0, C_NONE,  1, 0);  // 3 single bubble
        step(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, C_NONE,  1, 0);  // 4 rd=0 ignored
        step(0, 0, 0, 0, 7, 1, 7, 1, 0, 0, 0, C_LU,    1, 0);  // 5 load-use on rs2
        step(0, 0, 0, 0, 7, 0, 7, 1, 0, 0, 0, C_NONE,  2, 0);  // 6 rs2 not used
        step(0, 0, 5, 1, 0, 0, 5, 1, 1, 0, 0, C_BR,    2, 0);  // 7 branch beats load-use
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  2, 1);  // 8 clear
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  0, 0);  // 9
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STALL, 0, 0);  // 10 mem wait
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STALL, 1, 0);  // 11
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STALL, 2, 0);  // 12
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE,  3, 0);  // 13 ack releases
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  3, 0);  // 14
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE,  3, 0);  // 15 ack in request cycle
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STALL, 3, 0);  // 16 timeout run, stall_cnt saturated
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STALL, 3, 0);  // 17
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STALL, 3, 0);  // 18
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STALL, 3, 0);  // 19
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_TO,    3, 0);  // 20 abort cycle
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STALL, 3, 0);  // 21 fresh access from RUN
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE,  3, 0);  // 22
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  3, 0);  // 23 clear
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  0, 0);  // 24
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_STALL, 0, 0);  // 25 branch during stall
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_STALL, 1, 0);  // 26
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_BR,    2, 0);  // 27 redirect in ack cycle
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  2, 1);  // 28
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,    2, 1);  // 29 flush saturation
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,    2, 2);  // 30
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,    2, 3);  // 31
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  2, 3);  // 32
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,    2, 3);  // 33 clear beats increment
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  0, 0);  // 34
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STALL, 0, 0);  // 35 enter WAIT
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE,  0, 0);  // 36 reset mid-WAIT
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_STALL, 0, 0);  // 37 restart from RUN
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE,  1, 0);  // 38
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  1, 0);  // 39
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d responses left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipeline. Drives the suspend/flush pins of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Sources: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses (bounded by a timeout). Also keeps saturating stall/flush event counters for performance debug.

## Interface
- MEM_TIMEOUT, 16: maximum stall cycles for one memory access before abort (≥2).
- CNT_W, 32: width of the event counters.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_rs1_i  in  5  rs1 index of the instruction in ID.
- id_rs2_i  in  5  rs2 index of the instruction in ID.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- ex_rd_i  in  5  destination index of the instruction in EX.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_branch_taken_i  in  1  EX instruction redirects the PC (taken branch or jump).
- mem_req_i  in  1  MEM-stage instruction accesses data memory this cycle.
- mem_ack_i  in  1  data memory completes the access this cycle.
- cnt_clr_i  in  1  synchronous clear of both counters.
- pc_suspend_o  out  1  hold PC.
- if_id_suspend_o  out  1  hold IF/ID.
- if_id_flush_o  out  1  clear IF/ID.
- id_ex_suspend_o  out  1  hold ID/EX.
- id_ex_flush_o  out  1  clear ID/EX (bubble).
- ex_mem_suspend_o  out  1  hold EX/MEM.
- mem_wb_flush_o  out  1  clear MEM/WB (bubble).
- redirect_o  out  1  fetch takes the branch target this cycle.
- mem_timeout_o  out  1  one-cycle pulse: memory access aborted.
- stall_cnt_o  out  CNT_W  stall cycles counted.
- flush_cnt_o  out  CNT_W  branch flush cycles counted.

## Operation
- FSM states: RUN, WAIT. Register wait_cnt is ceil(log2(MEM_TIMEOUT+1)) bits wide.
- mem_stall is combinational:
  - RUN: mem_req_i & ~mem_ack_i.
  - WAIT: ~mem_ack_i & (wait_cnt < MEM_TIMEOUT).
- FSM transitions:
  - RUN with mem_stall → WAIT, wait_cnt ← 1.
  - WAIT with mem_ack_i → RUN.
  - WAIT, no ack, wait_cnt < MEM_TIMEOUT → stay in WAIT, wait_cnt++.
  - WAIT, no ack, wait_cnt == MEM_TIMEOUT → abort cycle: mem_stall=0, mem_timeout_o=1, next state RUN.
- load_use = ex_mem_read_i & (ex_rd_i≠0) & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)).
- Priority: mem_stall > branch > load_use. All outputs not listed for an action are 0.
  - mem_stall: pc, if_id, id_ex and ex_mem suspends = 1; mem_wb_flush_o=1.
  - ex_branch_taken_i (no mem_stall): redirect_o=1, if_id_flush_o=1, id_ex_flush_o=1. Any load_use is ignored because the ID instruction is discarded.
  - load_use only: pc_suspend_o=1, if_id_suspend_o=1, id_ex_flush_o=1.
- Counters:
  - stall_cnt increments in every cycle with mem_stall or an acted-on load_use.
  - flush_cnt increments in every cycle with an acted-on branch.
  - Both saturate at all-ones.
  - cnt_clr_i forces both to 0 and has priority over increment.

## Timing
- Every control output is combinational from inputs and state, with zero-cycle latency, so the pipeline registers sample it at the same clock edge.
- Reset: state=RUN, wait_cnt=0, counters=0. While rst_i is high, all control outputs are forced to 0.
- Reset asserted mid-WAIT returns to RUN immediately. No timeout pulse.
- Memory access:
  - Ack in the request cycle: no stall.
  - Ack after N stall cycles (N ≤ MEM_TIMEOUT): exactly N stall cycles; suspends drop in the ack cycle.
  - No ack: MEM_TIMEOUT stall cycles, then one abort cycle.
- A new mem_req_i in the cycle after an ack or abort starts a fresh access from RUN.
- Load-use produces exactly one bubble: the next cycle sees the load in MEM, so load_use=0.
- Counter updates become visible one cycle after the event.

## Test plan
- Load-use: EX lw rd=5, ID uses rs1=5 → exactly one cycle of pc/if_id suspend + id_ex flush; stall_cnt=1. Repeat with rd=0 → no action.
- Branch with simultaneous load_use: ex_branch_taken_i=1, load_use true → redirect_o, if_id_flush_o, id_ex_flush_o=1, both suspends 0; flush_cnt=1.
- Memory wait: mem_req_i=1, ack on the 4th cycle → 3 stall cycles with mem_wb_flush_o=1, release in the ack cycle; stall_cnt=3.
- Timeout with MEM_TIMEOUT=4 and ack held low → 4 stall cycles, then mem_timeout_o=1 for one cycle, then RUN.
- Branch asserted during a memory stall → only the stall outputs are driven; redirect occurs in the ack cycle.
- rst_i pulsed mid-WAIT → outputs 0 immediately, counters 0. Saturation check with CNT_W=2: the counter stops at 3; cnt_clr_i → 0.
